usb_bus_master: RTL and testbench

//  Initiator for the 8-bit async parallel target bus (addr[20:0], data[7:0], !RD, !WR, !CE).

---
 rtl/usb_bus_master_pkg.sv | 25 ++
 rtl/usb_bus_master_if.sv | 33 +++
 rtl/usb_bus_master.sv | 158 +++++++++++++++
 tb/tb_usb_bus_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_bus_master_pkg.sv
// Shared definitions for the async parallel bus initiator: bus widths,
// FSM state encoding and a small constant helper for sizing the phase counter.
package usb_bus_master_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_TURN   = 3'd4
  } state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/usb_bus_master_if.sv
// Command/response handshake plus target bus pins of the initiator.
// master = the initiator core, slave = the host/target environment.
interface usb_bus_master_if;
  import usb_bus_master_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data_out;
  logic              bus_data_oe;
  logic [DATA_W-1:0] bus_data_in;
  logic              bus_rd_n;
  logic              bus_wr_n;
  logic              bus_ce_n;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, bus_data_in,
    output cmd_ready, rsp_valid, rsp_rdata,
    output bus_addr, bus_data_out, bus_data_oe, bus_rd_n, bus_wr_n, bus_ce_n
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, bus_data_in,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  bus_addr, bus_data_out, bus_data_oe, bus_rd_n, bus_wr_n, bus_ce_n
  );

endinterface

// File: rtl/usb_bus_master.sv
// Single-byte initiator for the 8-bit async parallel target bus: turns a
// valid/ready command into registered !CE/!RD/!WR strobe timing and returns read data.
module usb_bus_master
  import usb_bus_master_pkg::*;
#(
  parameter int SETUP_CYCLES      = 1,
  parameter int STROBE_CYCLES     = 2,
  parameter int HOLD_CYCLES       = 1,
  parameter int TURNAROUND_CYCLES = 3
) (
  input  logic             clk_usb,
  input  logic             reset,
  usb_bus_master_if.master io
);

  localparam int MAXP  = max4(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, TURNAROUND_CYCLES);
  localparam int CNT_W = (MAXP < 1) ? 1 : $clog2(MAXP + 1);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LD   =
    CNT_W'((TURNAROUND_CYCLES > 0) ? TURNAROUND_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              oe_q, oe_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              ce_n_q, ce_n_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_q, rsp_d;

  // All pin state lives in registers so nothing from cmd_* reaches the pins combinationally.
  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      ce_n_q  <= 1'b1;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      ce_n_q  <= ce_n_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    ce_n_d  = ce_n_q;
    rdata_d = rdata_q;
    rsp_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (io.cmd_valid) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          write_d = io.cmd_write;
          addr_d  = io.cmd_addr;
          ce_n_d  = 1'b0;
          if (io.cmd_write) begin
            oe_d   = 1'b1;
            dout_d = io.cmd_wdata;
          end
        end
      end

      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
          if (write_q) wr_n_d = 1'b0;
          else         rd_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // Read data is taken on the edge that releases !RD, i.e. the last strobe cycle's value.
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          wr_n_d  = 1'b1;
          rd_n_d  = 1'b1;
          if (!write_q) rdata_d = io.bus_data_in;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          ce_n_d = 1'b1;
          oe_d   = 1'b0;
          if (write_q || (TURNAROUND_CYCLES == 0)) begin
            state_d = ST_IDLE;
            rsp_d   = 1'b1;
          end else begin
            state_d = ST_TURN;
            cnt_d   = TURN_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // Idle gap that lets the target finish extending its read drive.
      ST_TURN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          rsp_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign io.cmd_ready    = (state_q == ST_IDLE);
  assign io.rsp_valid    = rsp_q;
  assign io.rsp_rdata    = rdata_q;
  assign io.bus_addr     = addr_q;
  assign io.bus_data_out = dout_q;
  assign io.bus_data_oe  = oe_q;
  assign io.bus_rd_n     = rd_n_q;
  assign io.bus_wr_n     = wr_n_q;
  assign io.bus_ce_n     = ce_n_q;

endmodule

// File: tb/tb_usb_bus_master.sv
// Bench for usb_bus_master: three timing configurations share a 256-byte target
// memory; a transaction-level model predicts strobe windows, response timing and read data.
module tb_usb_bus_master;
  import usb_bus_master_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usb_bus_master_if if0();
  usb_bus_master_if if1();
  usb_bus_master_if if2();

  usb_bus_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1), .TURNAROUND_CYCLES(3))
    u_dut0 (.clk_usb(clk), .reset(rst), .io(if0));
  usb_bus_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2), .TURNAROUND_CYCLES(3))
    u_dut1 (.clk_usb(clk), .reset(rst), .io(if1));
  usb_bus_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .TURNAROUND_CYCLES(0))
    u_dut2 (.clk_usb(clk), .reset(rst), .io(if2));

  int S_of  [3] = '{1, 3, 1};
  int T_of  [3] = '{2, 4, 1};
  int H_of  [3] = '{1, 2, 1};
  int TA_of [3] = '{3, 3, 0};

  int sel = 0;
  logic              c_valid = 1'b0;
  logic              c_write = 1'b0;
  logic [ADDR_W-1:0] c_addr  = '0;
  logic [DATA_W-1:0] c_wdata = '0;

  assign if0.cmd_valid = c_valid && (sel == 0);
  assign if1.cmd_valid = c_valid && (sel == 1);
  assign if2.cmd_valid = c_valid && (sel == 2);
  assign if0.cmd_write = c_write;
  assign if1.cmd_write = c_write;
  assign if2.cmd_write = c_write;
  assign if0.cmd_addr  = c_addr;
  assign if1.cmd_addr  = c_addr;
  assign if2.cmd_addr  = c_addr;
  assign if0.cmd_wdata = c_wdata;
  assign if1.cmd_wdata = c_wdata;
  assign if2.cmd_wdata = c_wdata;

  // Target: 256-byte memory aliased on addr[7:0], drives data only while !RD is low.
  logic [7:0] tgt_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rdata [3];

  assign if0.bus_data_in = if0.bus_rd_n ? 8'hEE : tgt_mem[if0.bus_addr[7:0]];
  assign if1.bus_data_in = if1.bus_rd_n ? 8'hEE : tgt_mem[if1.bus_addr[7:0]];
  assign if2.bus_data_in = if2.bus_rd_n ? 8'hEE : tgt_mem[if2.bus_addr[7:0]];

  always @(posedge clk) begin
    if (!if0.bus_wr_n && if0.bus_data_oe) tgt_mem[if0.bus_addr[7:0]] <= if0.bus_data_out;
    if (!if1.bus_wr_n && if1.bus_data_oe) tgt_mem[if1.bus_addr[7:0]] <= if1.bus_data_out;
    if (!if2.bus_wr_n && if2.bus_data_oe) tgt_mem[if2.bus_addr[7:0]] <= if2.bus_data_out;
  end

  logic              m_ce_n, m_rd_n, m_wr_n, m_oe, m_rsp, m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout, m_rdata;

  always_comb begin
    m_ce_n = if0.bus_ce_n; m_rd_n = if0.bus_rd_n; m_wr_n = if0.bus_wr_n;
    m_oe = if0.bus_data_oe; m_rsp = if0.rsp_valid; m_ready = if0.cmd_ready;
    m_addr = if0.bus_addr; m_dout = if0.bus_data_out; m_rdata = if0.rsp_rdata;
    if (sel == 1) begin
      m_ce_n = if1.bus_ce_n; m_rd_n = if1.bus_rd_n; m_wr_n = if1.bus_wr_n;
      m_oe = if1.bus_data_oe; m_rsp = if1.rsp_valid; m_ready = if1.cmd_ready;
      m_addr = if1.bus_addr; m_dout = if1.bus_data_out; m_rdata = if1.rsp_rdata;
    end else if (sel == 2) begin
      m_ce_n = if2.bus_ce_n; m_rd_n = if2.bus_rd_n; m_wr_n = if2.bus_wr_n;
      m_oe = if2.bus_data_oe; m_rsp = if2.rsp_valid; m_ready = if2.cmd_ready;
      m_addr = if2.bus_addr; m_dout = if2.bus_data_out; m_rdata = if2.rsp_rdata;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (dut%0d): got %0h expected %0h", tag, sel, got, exp);
    end
  endtask

  // Entered just after a clock edge with the DUT idle; returns in the rsp_valid cycle.
  task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                         input bit garbage);
    int s, t, h, act, n;
    int ce_lo, ce_hi, st_lo, st_first, other_lo, both_lo, oe_cnt, dout_bad;
    int rsp_cnt, rsp_at, addr_bad;
    logic strobe, other;
    s = S_of[sel]; t = T_of[sel]; h = H_of[sel];
    act = s + t + h;
    n = act + (wr ? 0 : TA_of[sel]);
    ce_lo = 0; ce_hi = 0; st_lo = 0; st_first = -1; other_lo = 0; both_lo = 0;
    oe_cnt = 0; dout_bad = 0; rsp_cnt = 0; rsp_at = -1; addr_bad = 0;
    if (wr) ref_mem[a[7:0]] = d;
    else    exp_rdata[sel] = ref_mem[a[7:0]];

    c_write = wr; c_addr = a; c_wdata = d; c_valid = 1'b1;
    #1;
    chk("cmd_ready", 32'(m_ready), 32'd1);
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      if (!m_ce_n) ce_lo++; else ce_hi++;
      strobe = wr ? m_wr_n : m_rd_n;
      other  = wr ? m_rd_n : m_wr_n;
      if (!strobe) begin
        st_lo++;
        if (st_first < 0) st_first = i;
      end
      if (!other) other_lo++;
      if (!m_wr_n && !m_rd_n) both_lo++;
      if (m_oe) begin
        oe_cnt++;
        if (m_dout !== d) dout_bad++;
      end
      if (m_rsp) begin
        rsp_cnt++;
        if (rsp_at < 0) rsp_at = i;
      end
      if (m_addr !== a) addr_bad++;
      if (garbage && (i + 1 < n)) begin
        c_valid = 1'b1; c_write = 1'($urandom); c_addr = ADDR_W'($urandom); c_wdata = 8'($urandom);
      end else begin
        c_valid = 1'b0;
      end
    end
    chk("ce_low_cycles", 32'(ce_lo), 32'(act));
    chk("ce_high_tail", 32'(ce_hi), 32'(n - act + 1));
    chk("strobe_low_cycles", 32'(st_lo), 32'(t));
    chk("strobe_fall_offset", 32'(st_first), 32'(s));
    chk("other_strobe_low", 32'(other_lo), 32'd0);
    chk("rd_wr_overlap", 32'(both_lo), 32'd0);
    chk("oe_cycles", 32'(oe_cnt), wr ? 32'(act) : 32'd0);
    chk("data_out_bad", 32'(dout_bad), 32'd0);
    chk("rsp_count", 32'(rsp_cnt), 32'd1);
    chk("rsp_offset", 32'(rsp_at), 32'(n));
    chk("addr_latched", 32'(addr_bad), 32'd0);
    chk("rsp_rdata", 32'(m_rdata), 32'(exp_rdata[sel]));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk("idle_no_rsp", 32'(m_rsp), 32'd0);
    end
  endtask

  task automatic check_reset_pins();
    chk("rst_ce_n", 32'(m_ce_n), 32'd1);
    chk("rst_rd_n", 32'(m_rd_n), 32'd1);
    chk("rst_wr_n", 32'(m_wr_n), 32'd1);
    chk("rst_oe", 32'(m_oe), 32'd0);
    chk("rst_addr", 32'(m_addr), 32'd0);
    chk("rst_dout", 32'(m_dout), 32'd0);
    chk("rst_rsp", 32'(m_rsp), 32'd0);
    chk("rst_rdata", 32'(m_rdata), 32'd0);
    chk("rst_ready", 32'(m_ready), 32'd1);
  endtask

  task automatic reset_mid_write();
    logic [ADDR_W-1:0] a;
    int rsp_seen;
    a = 21'h0000C7;
    sel = 0;
    c_write = 1'b1; c_addr = a; c_wdata = ref_mem[a[7:0]]; c_valid = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
    repeat (S_of[0]) @(posedge clk);
    #2;
    chk("pre_rst_wr_low", 32'(m_wr_n), 32'd0);
    rst = 1'b1;
    #1;
    check_reset_pins();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) exp_rdata[k] = 8'h00;
    rsp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (m_rsp) rsp_seen++;
    end
    chk("abort_no_rsp", 32'(rsp_seen), 32'd0);
    run_txn(1'b1, 21'h0000D1, 8'h96, 1'b0);
    idle(1);
    run_txn(1'b0, 21'h1000D1, 8'h00, 1'b0);
    chk("post_rst_readback", 32'(m_rdata), 32'h96);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit wr, garb;
    logic [ADDR_W-1:0] a;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) begin
      tgt_mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    for (int k = 0; k < 3; k++) exp_rdata[k] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      check_reset_pins();
    end

    sel = 0;
    @(posedge clk); #1;
    run_txn(1'b1, 21'h000123, 8'hA5, 1'b0);
    idle(2);
    run_txn(1'b1, 21'h000105, 8'h3C, 1'b0);
    idle(1);
    run_txn(1'b0, 21'h000005, 8'h00, 1'b0);
    chk("loopback_rdata", 32'(m_rdata), 32'h3C);
    idle(2);
    run_txn(1'b0, 21'h0000AA, 8'h00, 1'b0);
    run_txn(1'b1, 21'h0000AA, 8'h77, 1'b0);
    idle(1);
    run_txn(1'b1, 21'h1ABC10, 8'h5E, 1'b1);
    idle(1);

    reset_mid_write();
    idle(1);

    sel = 1;
    #1;
    run_txn(1'b1, 21'h000045, 8'hC3, 1'b1);
    idle(1);
    run_txn(1'b0, 21'h000045, 8'h00, 1'b1);
    chk("slow_timing_rdata", 32'(m_rdata), 32'hC3);
    idle(1);

    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      for (int j = 0; j < 20; j++) begin
        wr = 1'($urandom);
        a = ADDR_W'($urandom);
        d = 8'($urandom);
        garb = 1'($urandom);
        run_txn(wr, a, d, garb);
        if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
      end
      idle(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
